// File: rtl/scaler_sfft_pkg.sv
// Shared definitions for the SFFT run-sequencer: FSM encoding and derived sizes.
package scaler_sfft_pkg;

    // Sequencer states; the numeric values are visible on the debug state output.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Number of bits in one unary bitstream window.
    function automatic int calc_streamlen(input int bitwidth);
        return 1 << bitwidth;
    endfunction

    // Lane counter width: must hold the value STREAMLEN itself.
    function automatic int calc_cntw(input int bitwidth);
        return bitwidth + 1;
    endfunction

    // Total enabled cycles: pipeline flush followed by the counted window.
    function automatic int calc_runlen(input int bitwidth, input int pipedepth);
        return pipedepth + calc_streamlen(bitwidth);
    endfunction

endpackage

// File: rtl/sfft_lane_counter.sv
// Saturating ones-counter for one SFFT output lane (unary -> binary).
module sfft_lane_counter
    import scaler_sfft_pkg::*;
#(
    parameter int CNTW      = 9,
    parameter int STREAMLEN = 256
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic            iClr,
    input  logic            iEn,
    output logic [CNTW-1:0] oCnt
);

    localparam logic [CNTW-1:0] SAT = CNTW'(STREAMLEN);

    logic [CNTW-1:0] cnt_q, cnt_d;

    // Clear wins over count; count stops at STREAMLEN instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (iClr) begin
            cnt_d = '0;
        end else if (iEn && (cnt_q != SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign oCnt = cnt_q;

endmodule

// File: rtl/scaler_sfft_ctrl.sv
// Run-sequencer for the stochastic radix-2 SFFT: loads the twiddle, clears and
// enables the datapath for a flush + bitstream window, counts ones per lane and
// hands the counts upstream.
//
// Result handshake: oValid is held high with stable counts until the cycle in
// which iResReady is also high; that edge completes the transfer and oValid
// drops on the following cycle. Start handshake: a request transfers on an
// edge where iStart && oReady; iStart while oReady is low is dropped.
module scaler_sfft_ctrl
    import scaler_sfft_pkg::*;
#(
    parameter int BITWIDTH  = 8,
    parameter int NUMINPUTS = 8,
    parameter int PIPEDEPTH = 3,
    parameter int CNTW      = calc_cntw(BITWIDTH)
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iStart,
    input  logic [BITWIDTH-1:0]       iwReal,
    input  logic [BITWIDTH-1:0]       iwImg,
    output logic                      oReady,
    output logic                      oSfftEn,
    output logic                      oSfftLoadW,
    output logic                      oSfftClr,
    output logic [BITWIDTH-1:0]       oSfftwReal,
    output logic [BITWIDTH-1:0]       oSfftwImg,
    input  logic [NUMINPUTS-1:0]      iSfftReal,
    input  logic [NUMINPUTS-1:0]      iSfftImg,
    output logic                      oRun,
    output logic                      oValid,
    input  logic                      iResReady,
    output logic [NUMINPUTS*CNTW-1:0] oCntReal,
    output logic [NUMINPUTS*CNTW-1:0] oCntImg,
    output logic [2:0]                oDbgState
);

    localparam int STREAMLEN = calc_streamlen(BITWIDTH);
    localparam int RUNLEN    = calc_runlen(BITWIDTH, PIPEDEPTH);
    localparam int RUNW      = $clog2(RUNLEN + 1);
    localparam logic [RUNW-1:0] LAST_CYC  = RUNW'(RUNLEN - 1);
    localparam logic [RUNW-1:0] FLUSH_CYC = RUNW'(PIPEDEPTH);

    state_e              state_q, state_d;
    logic                ready_q, load_q, clr_q, en_q, valid_q;
    logic [BITWIDTH-1:0] wreal_q, wimg_q;
    logic [RUNW-1:0]     cyc_q;
    logic                lane_clr, count_win;

    // Next-state logic for the sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (iStart) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_RUN;
            ST_RUN:   if (cyc_q == LAST_CYC) state_d = ST_DONE;
            ST_DONE:  if (iResReady) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register plus one flop per control output, decoded from the next
    // state so each strobe comes straight from a flop.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            load_q  <= 1'b0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_IDLE);
            load_q  <= (state_d == ST_LOAD);
            clr_q   <= (state_d == ST_CLEAR);
            en_q    <= (state_d == ST_RUN);
            valid_q <= (state_d == ST_DONE);
        end
    end

    // Twiddle register: captured only on an accepted start.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            wreal_q <= '0;
            wimg_q  <= '0;
        end else if ((state_q == ST_IDLE) && iStart) begin
            wreal_q <= iwReal;
            wimg_q  <= iwImg;
        end
    end

    // Run cycle counter: zeroed in CLEAR, advances once per RUN cycle.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            cyc_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            cyc_q <= '0;
        end else if (state_q == ST_RUN) begin
            cyc_q <= cyc_q + 1'b1;
        end
    end

    assign lane_clr  = (state_q == ST_CLEAR);
    assign count_win = (state_q == ST_RUN) && (cyc_q >= FLUSH_CYC);

    for (genvar k = 0; k < NUMINPUTS; k++) begin : g_lane
        sfft_lane_counter #(
            .CNTW      (CNTW),
            .STREAMLEN (STREAMLEN)
        ) u_cnt_real (
            .iClk (iClk),
            .iRst (iRst),
            .iClr (lane_clr),
            .iEn  (count_win && iSfftReal[k]),
            .oCnt (oCntReal[k*CNTW +: CNTW])
        );
        sfft_lane_counter #(
            .CNTW      (CNTW),
            .STREAMLEN (STREAMLEN)
        ) u_cnt_img (
            .iClk (iClk),
            .iRst (iRst),
            .iClr (lane_clr),
            .iEn  (count_win && iSfftImg[k]),
            .oCnt (oCntImg[k*CNTW +: CNTW])
        );
    end

    assign oReady     = ready_q;
    assign oSfftLoadW = load_q;
    assign oSfftClr   = clr_q;
    assign oSfftEn    = en_q;
    assign oRun       = en_q;
    assign oValid     = valid_q;
    assign oSfftwReal = wreal_q;
    assign oSfftwImg  = wimg_q;
    assign oDbgState  = state_q;

endmodule
